dot_operand_loader: RTL and testbench

Upstream feeder for the 32-element 8-bit dot-product engine. It accepts a byte stream over a valid/ready handshake: 32 bytes of operand A, then 32 bytes of operand B. It packs the bytes into two register arrays, pulses the engine's start, and waits for the engine's done. It then returns the 16-bit result over a valid/ready output, with an error flag if the engine never finishes.

---
 rtl/dot_operand_loader_if.sv | 20 ++
 rtl/dot_operand_loader.sv | 124 ++++++++++++
 tb/tb_dot_operand_loader.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dot_operand_loader_if.sv
// rtl/dot_operand_loader_if.sv - operand byte stream in, dot-product result out
interface dot_operand_loader_if;
   logic [7:0]  s_data;
   logic        s_valid;
   logic        s_ready;
   logic [15:0] r_data;
   logic        r_err;
   logic        r_valid;
   logic        r_ready;

   modport master (
      output s_data, s_valid, r_ready,
      input  s_ready, r_data, r_err, r_valid
   );

   modport slave (
      input  s_data, s_valid, r_ready,
      output s_ready, r_data, r_err, r_valid
   );
endinterface

// File: rtl/dot_operand_loader.sv
// rtl/dot_operand_loader.sv - packs A/B operand bytes, kicks the dot engine, returns its result
module dot_operand_loader #(
   parameter int VEC_LEN = 32,
   parameter int TIMEOUT = 256
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     abort,
   dot_operand_loader_if.slave      bus,
   output logic [VEC_LEN-1:0][7:0]  a_vec,
   output logic [VEC_LEN-1:0][7:0]  b_vec,
   output logic                     dot_start,
   input  logic                     dot_done,
   input  logic [15:0]              dot_c,
   output logic                     busy
);

   localparam int IW = $clog2(VEC_LEN) + 1;
   localparam int TW = $clog2(TIMEOUT) + 1;

   typedef enum logic [2:0] {
      FILL_A,
      FILL_B,
      KICK,
      WAIT_DONE,
      RESULT
   } state_t;

   state_t        state;
   logic [IW-1:0] idx;
   logic [TW-1:0] tcnt;
   logic          done_q;
   logic          beat;
   logic          last_beat;

   assign bus.s_ready = (state == FILL_A) || (state == FILL_B);
   assign busy        = !((state == FILL_A) && (idx == '0));
   assign beat        = bus.s_valid && bus.s_ready;
   assign last_beat   = (idx == IW'(VEC_LEN - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= FILL_A;
         idx         <= '0;
         tcnt        <= '0;
         done_q      <= 1'b0;
         a_vec       <= '0;
         b_vec       <= '0;
         dot_start   <= 1'b0;
         bus.r_data  <= '0;
         bus.r_err   <= 1'b0;
         bus.r_valid <= 1'b0;
      end else begin
         dot_start <= 1'b0;
         if (abort) begin
            // Operand arrays are deliberately left intact; only control state is flushed.
            state       <= FILL_A;
            idx         <= '0;
            tcnt        <= '0;
            bus.r_valid <= 1'b0;
            bus.r_err   <= 1'b0;
         end else begin
            case (state)
               FILL_A: begin
                  if (beat) begin
                     a_vec[idx[IW-2:0]] <= bus.s_data;
                     if (last_beat) begin
                        idx   <= '0;
                        state <= FILL_B;
                     end else begin
                        idx <= idx + IW'(1);
                     end
                  end
               end
               FILL_B: begin
                  if (beat) begin
                     b_vec[idx[IW-2:0]] <= bus.s_data;
                     if (last_beat) begin
                        idx       <= '0;
                        dot_start <= 1'b1;
                        state     <= KICK;
                     end else begin
                        idx <= idx + IW'(1);
                     end
                  end
               end
               KICK: begin
                  // Capturing done here makes a level left high by the last run look like no edge.
                  tcnt   <= '0;
                  done_q <= dot_done;
                  state  <= WAIT_DONE;
               end
               WAIT_DONE: begin
                  done_q <= dot_done;
                  if (dot_done && !done_q) begin
                     bus.r_data  <= dot_c;
                     bus.r_err   <= 1'b0;
                     bus.r_valid <= 1'b1;
                     state       <= RESULT;
                  end else if (tcnt == TW'(TIMEOUT - 1)) begin
                     bus.r_data  <= '0;
                     bus.r_err   <= 1'b1;
                     bus.r_valid <= 1'b1;
                     state       <= RESULT;
                  end else begin
                     tcnt <= tcnt + TW'(1);
                  end
               end
               RESULT: begin
                  if (bus.r_ready) begin
                     bus.r_valid <= 1'b0;
                     state       <= FILL_A;
                  end
               end
               default: begin
                  state <= FILL_A;
                  idx   <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dot_operand_loader.sv
// tb/tb_dot_operand_loader.sv - randomized self-checking bench for dot_operand_loader
module tb_dot_operand_loader;
   localparam int VL = 32;
   localparam int TO = 256;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                abort = 1'b0;
   logic [VL-1:0][7:0]  a_vec;
   logic [VL-1:0][7:0]  b_vec;
   logic                dot_start;
   logic                dot_done = 1'b0;
   logic [15:0]         dot_c = '0;
   logic                busy;

   dot_operand_loader_if bus ();

   dot_operand_loader #(.VEC_LEN(VL), .TIMEOUT(TO)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .abort     (abort),
      .bus       (bus.slave),
      .a_vec     (a_vec),
      .b_vec     (b_vec),
      .dot_start (dot_start),
      .dot_done  (dot_done),
      .dot_c     (dot_c),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int eng_lat  = 35;
   bit eng_sticky = 1'b0;
   int eng_cnt  = 0;
   int start_count = 0;
   logic [7:0] av [VL];
   logic [7:0] bv [VL];

   function automatic logic [15:0] engine_sum();
      int s = 0;
      for (int i = 0; i < VL; i++) s += int'(a_vec[i]) * int'(b_vec[i]);
      return s[15:0];
   endfunction

   // Engine stand-in: done rises eng_lat cycles after the start cycle
   always @(posedge clk) begin
      if (dot_start) start_count <= start_count + 1;
      if (!rst_n) begin
         dot_done <= 1'b0;
         dot_c    <= '0;
         eng_cnt  <= 0;
      end else if (eng_sticky) begin
         dot_done <= 1'b1;
      end else if (dot_start) begin
         dot_done <= 1'b0;
         eng_cnt  <= eng_lat - 1;
      end else if (eng_cnt > 0) begin
         eng_cnt <= eng_cnt - 1;
         if (eng_cnt == 1) begin
            dot_done <= 1'b1;
            dot_c    <= engine_sum();
         end
      end
   end

   function automatic logic [15:0] ref_result();
      int s = 0;
      for (int i = 0; i < VL; i++) s += int'(av[i]) * int'(bv[i]);
      return s[15:0];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input int cnt, input int gap_pct);
      int n = 0;
      int guard = 0;
      bit take;
      while (n < cnt && guard < 4000) begin
         guard++;
         bus.s_valid = ($urandom_range(99) >= gap_pct);
         bus.s_data  = (n < VL) ? av[n] : bv[n - VL];
         take = bus.s_valid && bus.s_ready;
         step();
         if (take) n++;
      end
      bus.s_valid = 1'b0;
      n_checks++;
      if (n != cnt) begin
         n_fail++;
         $display("FAIL feed_count: accepted %0d bytes, required %0d", n, cnt);
      end
   endtask

   task automatic run_op(input string name, input int gap, input int hold, input bit exp_err);
      int lat = 0;
      int bad = 0;
      logic [15:0] exp_data;
      logic [15:0] held;
      int exp_lat;
      exp_data = exp_err ? 16'h0 : ref_result();
      exp_lat  = exp_err ? TO + 1 : eng_lat + 1;
      feed(2 * VL, gap);
      n_checks++;
      if (dot_start !== 1'b1) begin
         n_fail++;
         $display("FAIL %s start_after_last_beat: dot_start=%b required 1", name, dot_start);
      end
      while (bus.r_valid !== 1'b1 && lat < TO + 50) begin
         step();
         lat++;
      end
      n_checks++;
      if (lat != exp_lat) begin
         n_fail++;
         $display("FAIL %s result_latency: %0d cycles after start, required %0d", name, lat, exp_lat);
      end
      n_checks++;
      if (bus.r_data !== exp_data || bus.r_err !== exp_err) begin
         n_fail++;
         $display("FAIL %s result: r_data=%h r_err=%b, required %h %b", name, bus.r_data, bus.r_err, exp_data, exp_err);
      end
      for (int i = 0; i < VL; i++)
         if (a_vec[i] !== av[i] || b_vec[i] !== bv[i]) bad++;
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL %s operand_arrays: %0d mismatching elements, a_vec[31]=%h required %h", name, bad, a_vec[VL-1], av[VL-1]);
      end
      held = bus.r_data;
      bad  = 0;
      for (int i = 0; i < hold; i++) begin
         step();
         if (bus.r_valid !== 1'b1 || bus.r_data !== held || bus.s_ready !== 1'b0) bad++;
      end
      if (hold > 0) begin
         n_checks++;
         if (bad != 0) begin
            n_fail++;
            $display("FAIL %s result_hold: %0d unstable cycles, required 0", name, bad);
         end
      end
      bus.r_ready = 1'b1;
      step();
      bus.r_ready = 1'b0;
      n_checks++;
      if (bus.r_valid !== 1'b0 || bus.s_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s accept: r_valid=%b s_ready=%b busy=%b, required 0 1 0", name, bus.r_valid, bus.s_ready, busy);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      n_checks++;
      if (a_vec !== '0 || b_vec !== '0 || dot_start !== 1'b0 || bus.r_data !== 16'h0 ||
          bus.r_err !== 1'b0 || bus.r_valid !== 1'b0 || busy !== 1'b0 || bus.s_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s: start=%b r_data=%h r_err=%b r_valid=%b busy=%b s_ready=%b, required all 0 and s_ready 1",
                  name, dot_start, bus.r_data, bus.r_err, bus.r_valid, busy, bus.s_ready);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) step();
      check_reset_outputs("reset_values");
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_base();
      int s0 = start_count;
      for (int i = 0; i < VL; i++) begin
         av[i] = 8'(i + 1);
         bv[i] = 8'd2;
      end
      eng_lat = 35;
      run_op("base", 0, 0, 1'b0);
      n_checks++;
      if (start_count - s0 != 1 || bus.r_data !== 16'd1056) begin
         n_fail++;
         $display("FAIL base_pulses: %0d starts r_data=%0d, required 1 and 1056", start_count - s0, bus.r_data);
      end
   endtask

   task automatic test_stalls();
      for (int i = 0; i < VL; i++) begin
         av[i] = 8'hFF;
         bv[i] = 8'hFF;
      end
      eng_lat = 20;
      run_op("stalls", 50, 10, 1'b0);
   endtask

   task automatic test_sticky();
      for (int i = 0; i < VL; i++) begin
         av[i] = 8'($urandom);
         bv[i] = 8'($urandom);
      end
      eng_sticky = 1'b1;
      run_op("sticky_done", 20, 0, 1'b1);
      eng_sticky = 1'b0;
   endtask

   task automatic test_abort();
      int s0 = start_count;
      for (int i = 0; i < VL; i++) begin
         av[i] = 8'($urandom);
         bv[i] = 8'($urandom);
      end
      feed(39, 0);
      abort = 1'b1;
      bus.s_valid = 1'b1;
      bus.s_data  = 8'hAA;
      step();
      abort = 1'b0;
      bus.s_valid = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || bus.s_ready !== 1'b1 || dot_start !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_flush: busy=%b s_ready=%b dot_start=%b, required 0 1 0", busy, bus.s_ready, dot_start);
      end
      for (int i = 0; i < VL; i++) begin
         av[i] = 8'd3;
         bv[i] = 8'd3;
      end
      eng_lat = 12;
      run_op("abort_reload", 0, 0, 1'b0);
      n_checks++;
      if (start_count - s0 != 1 || bus.r_data !== 16'd288) begin
         n_fail++;
         $display("FAIL abort_pulses: %0d starts r_data=%0d, required 1 and 288", start_count - s0, bus.r_data);
      end
   endtask

   task automatic test_reset_in_flight();
      for (int i = 0; i < VL; i++) begin
         av[i] = 8'($urandom);
         bv[i] = 8'($urandom);
      end
      eng_lat = 200;
      feed(2 * VL, 0);
      repeat (20) step();
      n_checks++;
      if (bus.r_valid !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL flight_waiting: r_valid=%b busy=%b, required 0 1", bus.r_valid, busy);
      end
      rst_n = 1'b0;
      #1;
      check_reset_outputs("reset_in_flight");
      step();
      check_reset_outputs("reset_in_flight_held");
      rst_n = 1'b1;
      step();
      for (int i = 0; i < VL; i++) begin
         av[i] = 8'($urandom);
         bv[i] = 8'($urandom);
      end
      eng_lat = 10;
      run_op("after_reset", 25, 0, 1'b0);
   endtask

   task automatic test_random();
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < VL; i++) begin
            av[i] = 8'($urandom);
            bv[i] = 8'($urandom);
         end
         eng_lat = $urandom_range(2, 100);
         run_op("random", $urandom_range(0, 60), $urandom_range(0, 5), 1'b0);
      end
   endtask

   initial begin
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.r_ready = 1'b0;
      test_reset();
      test_base();
      test_stalls();
      test_sticky();
      test_abort();
      test_reset_in_flight();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
